// File: rtl/mul_rs_pkg.sv
// Shared parameters, entry layout and operand-wakeup helper for the multiply
// reservation station.
package mul_rs_pkg;

  localparam int RS_DEPTH = 4;
  localparam int PTAG_W   = 5;
  localparam int ROB_W    = 5;
  localparam int DATA_W   = 16;
  localparam int CNT_W    = 3;

  typedef struct packed {
    logic              valid;
    logic [PTAG_W-1:0] pw;
    logic [ROB_W-1:0]  tag;
    logic [PTAG_W-1:0] pa;
    logic [PTAG_W-1:0] pb;
    logic              rdy_a;
    logic              rdy_b;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } rs_entry_t;

  localparam rs_entry_t RS_EMPTY = rs_entry_t'({$bits(rs_entry_t){1'b0}});

  // Capture a CDB result into any waiting operand; port 0 wins, tag 0 never wakes.
  function automatic rs_entry_t wake_entry(
    input rs_entry_t         e,
    input logic              v0,
    input logic [PTAG_W-1:0] t0,
    input logic [DATA_W-1:0] r0,
    input logic              v1,
    input logic [PTAG_W-1:0] t1,
    input logic [DATA_W-1:0] r1
  );
    rs_entry_t res;
    logic h0a, h1a, h0b, h1b;
    res = e;
    h0a = e.valid && !e.rdy_a && v0 && (t0 != {PTAG_W{1'b0}}) && (t0 == e.pa);
    h1a = e.valid && !e.rdy_a && v1 && (t1 != {PTAG_W{1'b0}}) && (t1 == e.pa);
    h0b = e.valid && !e.rdy_b && v0 && (t0 != {PTAG_W{1'b0}}) && (t0 == e.pb);
    h1b = e.valid && !e.rdy_b && v1 && (t1 != {PTAG_W{1'b0}}) && (t1 == e.pb);
    if (h0a) begin
      res.rdy_a = 1'b1;
      res.a     = r0;
    end else if (h1a) begin
      res.rdy_a = 1'b1;
      res.a     = r1;
    end else begin
      res.rdy_a = e.rdy_a;
    end
    if (h0b) begin
      res.rdy_b = 1'b1;
      res.b     = r0;
    end else if (h1b) begin
      res.rdy_b = 1'b1;
      res.b     = r1;
    end else begin
      res.rdy_b = e.rdy_b;
    end
    return res;
  endfunction

endpackage

// File: rtl/mul_rs_select.sv
// Oldest-ready picker: grants the lowest-index set bit of the ready vector.
module mul_rs_select
  import mul_rs_pkg::*;
(
  input  logic [RS_DEPTH-1:0] ready_i,
  output logic [RS_DEPTH-1:0] grant_o,
  output logic                found_o
);

  // x & -x isolates the lowest set bit, i.e. the oldest ready entry.
  assign grant_o = ready_i & (~ready_i + {{(RS_DEPTH-1){1'b0}}, 1'b1});
  assign found_o = |ready_i;

endmodule

// File: rtl/mul_issue_queue.sv
// Four-entry age-ordered issue queue for the multiplier: collapsing storage,
// CDB wakeup, oldest-ready issue with back-end freeze and flush.
module mul_issue_queue
  import mul_rs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze_back,
  input  logic              valid_dp,
  input  logic [PTAG_W-1:0] Pw_dp,
  input  logic [ROB_W-1:0]  tag_ROB_dp,
  input  logic [PTAG_W-1:0] Pa_dp,
  input  logic [PTAG_W-1:0] Pb_dp,
  input  logic              rdy_a_dp,
  input  logic              rdy_b_dp,
  input  logic [DATA_W-1:0] busA_dp,
  input  logic [DATA_W-1:0] busB_dp,
  input  logic              valid_cdb0,
  input  logic [PTAG_W-1:0] Pw_cdb0,
  input  logic [DATA_W-1:0] Result_cdb0,
  input  logic              valid_cdb1,
  input  logic [PTAG_W-1:0] Pw_cdb1,
  input  logic [DATA_W-1:0] Result_cdb1,
  output logic              valid_mul,
  output logic [PTAG_W-1:0] Pw_mul,
  output logic [DATA_W-1:0] busA_mul,
  output logic [DATA_W-1:0] busB_mul,
  output logic [ROB_W-1:0]  tag_ROB_mul,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  rs_entry_t ent_q [RS_DEPTH];
  rs_entry_t ent_d [RS_DEPTH];
  rs_entry_t wk_s  [RS_DEPTH+1];
  rs_entry_t dp_s;
  rs_entry_t new_s;

  logic [CNT_W-1:0]    count_q, count_d, wpos_s;
  logic [RS_DEPTH-1:0] ready_s, grant_s;
  logic [1:0]          sel_s;
  logic                found_s, issue_s, accept_s, full_s;

  logic              valid_mul_q, valid_mul_d;
  logic [PTAG_W-1:0] pw_mul_q, pw_mul_d;
  logic [DATA_W-1:0] a_mul_q, a_mul_d;
  logic [DATA_W-1:0] b_mul_q, b_mul_d;
  logic [ROB_W-1:0]  tag_mul_q, tag_mul_d;

  // Eligibility and grant index, from registered entries only.
  always_comb begin
    ready_s = {RS_DEPTH{1'b0}};
    sel_s   = 2'd0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready_s[i] = ent_q[i].valid && ent_q[i].rdy_a && ent_q[i].rdy_b;
      sel_s      = sel_s | (grant_s[i] ? 2'(i) : 2'd0);
    end
  end

  mul_rs_select u_select (
    .ready_i (ready_s),
    .grant_o (grant_s),
    .found_o (found_s)
  );

  assign full_s   = (count_q == 3'd4);
  assign issue_s  = found_s && !freeze_back;
  assign accept_s = valid_dp && !full_s && !flush;
  assign wpos_s   = count_q - {2'b00, issue_s};

  // Entry next state: wake, collapse over the issued slot, append dispatch.
  always_comb begin
    dp_s.valid = 1'b1;
    dp_s.pw    = Pw_dp;
    dp_s.tag   = tag_ROB_dp;
    dp_s.pa    = Pa_dp;
    dp_s.pb    = Pb_dp;
    dp_s.rdy_a = rdy_a_dp;
    dp_s.rdy_b = rdy_b_dp;
    dp_s.a     = busA_dp;
    dp_s.b     = busB_dp;
    new_s = wake_entry(dp_s, valid_cdb0, Pw_cdb0, Result_cdb0,
                       valid_cdb1, Pw_cdb1, Result_cdb1);
    wk_s[RS_DEPTH] = RS_EMPTY;
    for (int i = 0; i < RS_DEPTH; i++) begin
      wk_s[i] = wake_entry(ent_q[i], valid_cdb0, Pw_cdb0, Result_cdb0,
                           valid_cdb1, Pw_cdb1, Result_cdb1);
    end
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (issue_s && (3'(i) >= {1'b0, sel_s})) begin
        ent_d[i] = wk_s[i+1];
      end else begin
        ent_d[i] = wk_s[i];
      end
      if (accept_s && (3'(i) == wpos_s)) begin
        ent_d[i] = new_s;
      end else begin
        ent_d[i] = ent_d[i];
      end
      if (flush) begin
        ent_d[i] = RS_EMPTY;
      end else begin
        ent_d[i] = ent_d[i];
      end
    end
  end

  // Occupancy and issue-port next state; flush beats freeze.
  always_comb begin
    count_d     = count_q + {2'b00, accept_s} - {2'b00, issue_s};
    valid_mul_d = valid_mul_q;
    pw_mul_d    = pw_mul_q;
    a_mul_d     = a_mul_q;
    b_mul_d     = b_mul_q;
    tag_mul_d   = tag_mul_q;
    if (flush) begin
      count_d     = 3'd0;
      valid_mul_d = 1'b0;
      pw_mul_d    = {PTAG_W{1'b0}};
      a_mul_d     = {DATA_W{1'b0}};
      b_mul_d     = {DATA_W{1'b0}};
      tag_mul_d   = {ROB_W{1'b0}};
    end else if (issue_s) begin
      valid_mul_d = 1'b1;
      pw_mul_d    = ent_q[sel_s].pw;
      a_mul_d     = ent_q[sel_s].a;
      b_mul_d     = ent_q[sel_s].b;
      tag_mul_d   = ent_q[sel_s].tag;
    end else if (!freeze_back) begin
      valid_mul_d = 1'b0;
    end else begin
      valid_mul_d = valid_mul_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= RS_EMPTY;
      count_q     <= 3'd0;
      valid_mul_q <= 1'b0;
      pw_mul_q    <= {PTAG_W{1'b0}};
      a_mul_q     <= {DATA_W{1'b0}};
      b_mul_q     <= {DATA_W{1'b0}};
      tag_mul_q   <= {ROB_W{1'b0}};
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q     <= count_d;
      valid_mul_q <= valid_mul_d;
      pw_mul_q    <= pw_mul_d;
      a_mul_q     <= a_mul_d;
      b_mul_q     <= b_mul_d;
      tag_mul_q   <= tag_mul_d;
    end
  end

  assign valid_mul   = valid_mul_q;
  assign Pw_mul      = pw_mul_q;
  assign busA_mul    = a_mul_q;
  assign busB_mul    = b_mul_q;
  assign tag_ROB_mul = tag_mul_q;
  assign full        = full_s;
  assign count       = count_q;

endmodule

// File: doc/mul_issue_queue.md
MUL_ISSUE_QUEUE -- requirements
Module: mul_issue_queue

Interface
REQ-001 SHALL expose: clk  in  1  sole clock; all state updates on posedge.
REQ-002 SHALL expose: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL expose: flush  in  1  squash all queued and issued work; freeze_back  in  1  back-end stall.
REQ-004 SHALL expose dispatch: valid_dp in 1; Pw_dp in 5; tag_ROB_dp in 5; Pa_dp, Pb_dp in 5 each; rdy_a_dp, rdy_b_dp in 1 each; busA_dp, busB_dp in 16 each (valid only when the matching rdy is 1).
REQ-005 SHALL expose wakeup ports k=0,1: valid_cdbk in 1; Pw_cdbk in 5; Result_cdbk in 16.
REQ-006 SHALL expose issue outputs: valid_mul out 1; Pw_mul out 5; busA_mul, busB_mul out 16; tag_ROB_mul out 5 (all registered).
REQ-007 SHALL expose status: full out 1; count out 3 (occupied entries, 0..4).

Function
REQ-008 Storage SHALL be 4 age-ordered entries, entry 0 oldest; each holds valid, Pw, tag_ROB, Pa, Pb, rdy_a, rdy_b, A, B.
REQ-009 full SHALL equal (count==4), computed from registered state only.
REQ-010 Dispatch SHALL be accepted when valid_dp && !full && !flush; the new entry is written at the youngest free position after any same-cycle removal.
REQ-011 Dispatch while full SHALL be ignored with no state change; a same-cycle issue SHALL NOT make room for it.
REQ-012 Wakeup: for each valid entry operand with rdy=0, tag match against a valid_cdbk with Pw_cdbk!=0 SHALL set rdy=1 and capture Result_cdbk at the edge.
REQ-013 Wakeup SHALL also apply to the entry being dispatched in the same cycle; cdb0 wins if both ports match one operand.
REQ-014 Broadcasts with Pw_cdbk==0 SHALL never wake any operand.
REQ-015 Selection SHALL pick the lowest-index valid entry with rdy_a && rdy_b, evaluated on registered state; wakeups in the current cycle make an entry eligible next cycle, not this one.
REQ-016 When !freeze_back and an entry is selected: it SHALL be removed, younger entries shift down by one, and its Pw/A/B/tag_ROB SHALL appear on the issue outputs with valid_mul=1 after the edge (1-cycle latency from eligibility).
REQ-017 When !freeze_back and nothing is eligible, valid_mul SHALL become 0; the other issue outputs MAY hold stale values.
REQ-018 While freeze_back=1, issue outputs SHALL hold and no entry SHALL be removed; dispatch and wakeup SHALL continue.
REQ-019 flush SHALL, at the next edge, invalidate all entries, set count=0, and clear all issue outputs to 0; flush overrides dispatch, wakeup, issue and freeze_back.
REQ-020 Order among non-selected entries SHALL be preserved across shifts; count SHALL change by (+1 accepted dispatch) and (-1 issue) in the same cycle.

Reset
REQ-021 While rst=1 at posedge, all entries SHALL be invalidated and valid_mul, Pw_mul, busA_mul, busB_mul, tag_ROB_mul, count SHALL be 0; full SHALL be 0.
REQ-022 Reset mid-operation SHALL discard all in-flight entries; no issue SHALL occur on the reset edge.

Structure
REQ-023 Shared package mul_rs_pkg SHALL hold RS_DEPTH=4, PTAG_W=5, ROB_W=5, DATA_W=16 and the entry struct typedef.
REQ-024 Oldest-ready selection SHALL be a sub-module mul_rs_select (4 ready bits in, one-hot grant + found out); the rest is one module.

Verification
REQ-025 Dispatch Pw=3, A=5, B=7, both rdy, tag_ROB=9 into empty queue -> next cycle valid_mul=1, busA_mul=5, busB_mul=7, Pw_mul=3, tag_ROB_mul=9, count back to 0.
REQ-026 Dispatch entry with rdy_b=0, Pb=12; cdb1 broadcasts Pw=12, Result=0x00FF two cycles later -> issue one cycle after the broadcast with busB_mul=0x00FF.
REQ-027 Fill 4 non-ready entries -> full=1; 5th dispatch, and a dispatch in the cycle entry 0 issues, both ignored; count stays correct.
REQ-028 Entries 0 and 2 ready, freeze_back=1 for 3 cycles -> outputs hold, no removal; after release entry 0 issues first, then entry 2 (now index 1).
REQ-029 flush with 3 queued and valid_mul=1 -> next cycle count=0, valid_mul=0, full=0; a dispatch asserted with flush is dropped.
REQ-030 Broadcast Pw=0 while an entry waits on Pa=0 -> entry stays not ready and never issues.
